// File: rtl/match_dot_accum_pkg.sv
// Shared types and default widths for the sparse dot-product path.
// The pair word layout matches the index comparison stage's FIFO word.
package sparse_pkg;
   localparam int IDX_W = 16;
   localparam int VAL_W = 16;
   localparam int ACC_W = 40;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [IDX_W-1:0] a_idx;
      logic [IDX_W-1:0] b_idx;
   } idx_pair_t;

   typedef enum logic [1:0] {RUN, DRAIN, OUT} dacc_state_t;
endpackage

// File: rtl/match_dot_accum_mul.sv
// S2: signed product register plus the valid/kill/last sideband that travels with it.
module dacc_mul_stage #(
   parameter int VAL_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_vld,
   input  logic                      in_kill,
   input  logic                      in_last,
   input  logic signed [VAL_W-1:0]   a,
   input  logic signed [VAL_W-1:0]   b,
   output logic                      out_vld,
   output logic                      out_kill,
   output logic                      out_last,
   output logic signed [2*VAL_W-1:0] prod
);
   logic signed [2*VAL_W-1:0] ax, bx;
   assign ax = a;
   assign bx = b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld  <= 1'b0;
         out_kill <= 1'b0;
         out_last <= 1'b0;
         prod     <= '0;
      end else begin
         out_vld  <= in_vld;
         out_kill <= in_kill;
         out_last <= in_last;
         if (in_vld) prod <= ax * bx;
      end
   end
endmodule

// File: rtl/match_dot_accum.sv
// Matched-pair dot-product accumulator: S1 address, RAM return, S2 multiply, S3 accumulate,
// then one result per pass over a valid/ready output.
module match_dot_accum #(
   parameter int IDX_W = sparse_pkg::IDX_W,
   parameter int VAL_W = sparse_pkg::VAL_W,
   parameter int ACC_W = sparse_pkg::ACC_W,
   parameter int CNT_W = sparse_pkg::CNT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pair_valid,
   output logic                    pair_ready,
   input  logic [2*IDX_W-1:0]      pair_data,
   input  logic                    pair_last,
   input  logic                    pair_null,
   output logic [IDX_W-1:0]        a_raddr,
   output logic [IDX_W-1:0]        b_raddr,
   input  logic signed [VAL_W-1:0] a_rdata,
   input  logic signed [VAL_W-1:0] b_rdata,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [ACC_W-1:0]        res_data,
   output logic [CNT_W-1:0]        res_count,
   output logic                    res_ovf
);
   import sparse_pkg::*;

   dacc_state_t state;
   logic        rdy_q, accept;
   // [0] = S1 (address issued), [1] = RAM data returning
   logic [1:0]  vld_pipe, kill_pipe, last_pipe;
   logic        m_vld, m_kill, m_last, done_last;
   logic signed [2*VAL_W-1:0] prod;
   logic signed [ACC_W-1:0]   pext, acc, sum;
   logic [CNT_W-1:0]          cnt;
   logic                      ovf, ovf_add;

   // Held low combinationally during reset, high the moment reset releases.
   assign pair_ready = rdy_q & rst_n;
   assign accept     = pair_valid & pair_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         kill_pipe <= '0;
         last_pipe <= '0;
         a_raddr   <= '0;
         b_raddr   <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[0], accept};
         kill_pipe <= {kill_pipe[0], pair_null};
         last_pipe <= {last_pipe[0], pair_last};
         if (accept) begin
            a_raddr <= pair_data[2*IDX_W-1:IDX_W];
            b_raddr <= pair_data[IDX_W-1:0];
         end
      end
   end

   dacc_mul_stage #(.VAL_W(VAL_W)) u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (vld_pipe[1]),
      .in_kill  (kill_pipe[1]),
      .in_last  (last_pipe[1]),
      .a        (a_rdata),
      .b        (b_rdata),
      .out_vld  (m_vld),
      .out_kill (m_kill),
      .out_last (m_last),
      .prod     (prod)
   );

   assign pext    = prod;
   assign sum     = acc + pext;
   assign ovf_add = (acc[ACC_W-1] == pext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         rdy_q     <= 1'b1;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_count <= '0;
         res_ovf   <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         done_last <= 1'b0;
      end else begin
         done_last <= m_vld & m_last;
         if (m_vld && !m_kill) begin
            acc <= sum;
            ovf <= ovf | ovf_add;
            if (cnt != '1) cnt <= cnt + 1'b1;
         end
         case (state)
            RUN: if (accept && pair_last) begin
               state <= DRAIN;
               rdy_q <= 1'b0;
            end
            // No beats are in flight behind the last one, so the clear never races an add.
            DRAIN: if (done_last) begin
               state     <= OUT;
               res_valid <= 1'b1;
               res_data  <= acc;
               res_count <= cnt;
               res_ovf   <= ovf;
               acc       <= '0;
               cnt       <= '0;
               ovf       <= 1'b0;
            end
            OUT: if (res_ready) begin
               state     <= RUN;
               rdy_q     <= 1'b1;
               res_valid <= 1'b0;
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_match_dot_accum.sv
// Randomized bench for match_dot_accum against a per-pass arithmetic reference model.
module tb_match_dot_accum;
   import sparse_pkg::*;
   localparam int IW = 16, VW = 16, AW = 32, CW = 16;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic pair_valid = 1'b0, pair_ready, pair_last = 1'b0, pair_null = 1'b0;
   logic [2*IW-1:0] pair_data = '0;
   logic [IW-1:0] a_raddr, b_raddr;
   logic signed [VW-1:0] a_rdata, b_rdata;
   logic res_valid, res_ready = 1'b0, res_ovf;
   logic [AW-1:0] res_data;
   logic [CW-1:0] res_count;

   match_dot_accum #(.IDX_W(IW), .VAL_W(VW), .ACC_W(AW), .CNT_W(CW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_data(pair_data),
      .pair_last(pair_last), .pair_null(pair_null),
      .a_raddr(a_raddr), .b_raddr(b_raddr), .a_rdata(a_rdata), .b_rdata(b_rdata),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_count(res_count), .res_ovf(res_ovf)
   );

   logic signed [VW-1:0] ram_a [256];
   logic signed [VW-1:0] ram_b [256];
   always @(posedge clk) begin
      a_rdata <= ram_a[a_raddr[7:0]];
      b_rdata <= ram_b[b_raddr[7:0]];
   end

   int n_chk = 0, n_pass = 0;
   int q_a[$], q_b[$];
   bit q_n[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Dot product of the queued pass in true integer arithmetic, wrapped to AW bits.
   function automatic void model(output logic [AW-1:0] s, output logic [CW-1:0] c, output bit o);
      longint acc = 0;
      int n = 0;
      o = 1'b0;
      foreach (q_a[i]) if (!q_n[i]) begin
         acc += longint'(ram_a[q_a[i]]) * longint'(ram_b[q_b[i]]);
         if (acc > 64'sd2147483647 || acc < -64'sd2147483648) o = 1'b1;
         acc = longint'(int'(acc));
         n++;
      end
      s = acc[AW-1:0];
      c = (n > 65535) ? CW'(65535) : CW'(n);
   endfunction

   task automatic send_beat(input int a, input int b, input bit last, input bit nul, input bit gaps);
      int budget = 0;
      bit took = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
         @(negedge clk);
         pair_valid = 1'b0;
      end
      @(negedge clk);
      pair_valid = 1'b1;
      pair_data  = idx_pair_t'{a_idx: IW'(a), b_idx: IW'(b)};
      pair_last  = last;
      pair_null  = nul;
      while (!took && budget < 50) begin
         took = pair_ready;
         @(posedge clk);
         budget++;
         if (!took) @(negedge clk);
      end
      if (!took) chk("accept_timeout", 0, 1);
      #1 pair_valid = 1'b0;
      q_a.push_back(a); q_b.push_back(b); q_n.push_back(nul);
   endtask

   // Entered 1 time unit after the edge that accepted the last beat.
   task automatic finish_pass(input string nm, input int hold);
      logic [AW-1:0] es; logic [CW-1:0] ec; bit eo;
      bit early = 1'b0, rdy_seen = 1'b0, moved = 1'b0;
      model(es, ec, eo);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         if (res_valid) early = 1'b1;
         if (pair_ready) rdy_seen = 1'b1;
      end
      chk({nm, "_early"}, early, 0);
      @(posedge clk); #1;
      chk({nm, "_lat"}, res_valid, 1);
      chk({nm, "_data"}, res_data, es);
      chk({nm, "_count"}, res_count, ec);
      chk({nm, "_ovf"}, res_ovf, eo);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if (!res_valid || res_data != es || res_count != ec || res_ovf != eo) moved = 1'b1;
         if (pair_ready) rdy_seen = 1'b1;
      end
      if (hold > 0) chk({nm, "_hold"}, moved, 0);
      chk({nm, "_rdy_low"}, rdy_seen, 0);
      @(negedge clk); res_ready = 1'b1;
      @(posedge clk); #1; res_ready = 1'b0;
      chk({nm, "_vld_drop"}, res_valid, 0);
      chk({nm, "_rdy_back"}, pair_ready, 1);
      q_a.delete(); q_b.delete(); q_n.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      for (int i = 0; i < 256; i++) begin
         ram_a[i] = VW'($urandom);
         ram_b[i] = VW'($urandom);
      end
      ram_a[1] = 3;  ram_a[5] = -4; ram_a[9] = 2;
      ram_b[2] = 10; ram_b[5] = 6;  ram_b[7] = -1;
      ram_a[20] = 32767; ram_b[21] = 32767;
      ram_a[11] = 7; ram_b[12] = 6;
      ram_a[3] = 5;  ram_b[4] = 5;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", pair_ready, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_data", res_data, 0);
      chk("rst_count", res_count, 0);
      chk("rst_ovf", res_ovf, 0);
      chk("rst_addr", {a_raddr, b_raddr}, 0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("post_rst_ready", pair_ready, 1);

      send_beat(1, 2, 0, 0, 0); send_beat(5, 5, 0, 0, 0); send_beat(9, 7, 1, 0, 0);
      chk("single_addr", {a_raddr, b_raddr}, {16'd9, 16'd7});
      finish_pass("single", 0);
      chk("addr_hold", {a_raddr, b_raddr}, {16'd9, 16'd7});

      send_beat(0, 0, 1, 1, 0);
      finish_pass("empty", 0);

      send_beat(1, 2, 0, 0, 0); send_beat(5, 5, 0, 0, 0); send_beat(9, 7, 1, 0, 0);
      finish_pass("bp", 10);

      for (int i = 1; i <= 8; i++) send_beat(20, 21, i == 8, 0, 0);
      finish_pass("ovf", 0);
      send_beat(1, 2, 0, 0, 0); send_beat(9, 7, 1, 0, 0);
      finish_pass("ovf_clear", 0);

      send_beat(3, 4, 1, 0, 0);
      q_a.delete(); q_b.delete(); q_n.delete();
      @(negedge clk); rst_n = 1'b0;
      #1 chk("midrst_ready", pair_ready, 0);
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (res_valid) seen = 1'b1;
      end
      chk("midrst_no_res", seen, 0);
      send_beat(11, 12, 1, 0, 0);
      finish_pass("fresh", 0);

      for (int i = 1; i <= 200; i++)
         send_beat($urandom_range(0, 255), $urandom_range(0, 255), i == 200, 0, 1);
      finish_pass("stream", 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/match_dot_accum.md
# match_dot_accum

Downstream consumer of the parallel index comparison stage. Pops matched index pairs {a_idx, b_idx}, fetches the corresponding nonzero values of A and B from two synchronous value RAMs, multiplies them and accumulates one dot product per row/column pass. It emits one result per pass over a valid/ready output.

## Interface
- IDX_W, 16, index width; pair word is 2*IDX_W, a_idx in the upper half, b_idx in the lower half
- VAL_W, 16, signed value width
- ACC_W, 40, signed accumulator width (must be ≥ 2*VAL_W)
- CNT_W, 16, match-counter width
- clk  in  1  single clock; all state on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- pair_valid  in  1  pair beat offered
- pair_ready  out  1  beat accepted when pair_valid && pair_ready
- pair_data  in  2*IDX_W  {a_idx, b_idx}
- pair_last  in  1  final beat of the current dot product
- pair_null  in  1  beat carries no match (contributes 0, not counted); legal only with pair_last
- a_raddr / b_raddr  out  IDX_W  value-RAM read addresses
- a_rdata / b_rdata  in  VAL_W  signed RAM data, valid exactly 1 cycle after address
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid && res_ready
- res_data  out  ACC_W  dot product
- res_count  out  CNT_W  number of non-null matches accumulated
- res_ovf  out  1  sticky: accumulator wrapped during this pass

## Operation
- FSM states: RUN, DRAIN, OUT. Reset → RUN.
- RUN: pair_ready=1. Each accepted beat enters a 3-stage pipeline: S1 register addresses; S2 RAM data returns and the product a_rdata*b_rdata (signed, 2*VAL_W) is registered; S3 accumulates the sign-extended product into acc.
- Null beats travel the pipeline with a kill bit: no add, no count.
- Accepting a beat with pair_last → DRAIN; pair_ready=0.
- DRAIN: wait until the last-tagged beat has completed S3 → OUT; capture acc, count and ovf into the result registers; clear acc, count and ovf.
- OUT: res_valid=1; hold res_* stable until res_ready; on handshake → RUN.
- pair_last without pair_null: the beat is a real match and is included in the result.
- Arithmetic: accumulation is modulo 2^ACC_W. ovf is set when the signed add overflows (operands share a sign, result differs). It stays set until the result is captured.
- Counter saturates at 2^CNT_W−1; it never wraps.
- a_raddr/b_raddr hold their last value when no beat is accepted.

## Timing
- Reset values: pair_ready=1 after deassertion (0 while rst_n low); res_valid=0, res_data=0, res_count=0, res_ovf=0, a_raddr=b_raddr=0. Accumulator, counter and pipeline valid bits all cleared.
- Throughput: 1 beat/cycle in RUN, with no dependence on pair_valid gaps.
- Latency: last beat accepted at edge t → res_valid high after edge t+4.
- Minimum gap between passes: the cycle after the result handshake, pair_ready=1 again.
- res_ready held high in OUT: res_valid lasts exactly one cycle.
- Reset asserted mid-pass (any state) discards in-flight beats and any pending result.

## Structure
- Shared package sparse_pkg holds:
  - IDX_W, VAL_W, ACC_W, CNT_W defaults
  - typedef struct packed idx_pair_t {a_idx, b_idx}, matching the comparison stage's FIFO word layout
  - enum dacc_state_t {RUN, DRAIN, OUT}
- One sub-module, dacc_mul_stage: the S2 signed multiply register with its valid/kill/last sideband. The FSM, S1 and S3 stay in the top.

## Test plan
- Single pass: pairs (1,2),(5,5),(9,7, last); RAM A[1]=3, A[5]=−4, A[9]=2; B[2]=10, B[5]=6, B[7]=−1 → res_data=3*10+(−4)*6+2*(−1)=4, res_count=3, res_ovf=0, res_valid 4 cycles after last accept.
- Empty pass: one beat with pair_last=1, pair_null=1 → res_data=0, res_count=0.
- Back-pressure: res_ready low 10 cycles in OUT → res_* stable, pair_ready=0 throughout; handshake → pair_ready=1 the next cycle.
- Overflow: ACC_W=32, VAL_W=16, eight beats of 32767*32767 → res_data equals the sum mod 2^32 as signed, res_ovf=1. The next pass with small values returns res_ovf=0.
- Reset mid-DRAIN: rst_n low for 1 cycle after a last beat → no res_valid. A fresh single pass (A=7, B=6) → 42.
- Streaming: 200 back-to-back beats with random pair_valid gaps, last on beat 200 → result matches the reference-model sum and count=200.
